// File: rtl/alarm_timer.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_timer
//  Description : BCD mm:ss countdown timer answering the watch's timer
//                handshake. A rising edge on tim_en loads a clamped preset,
//                counts it down once per TICK_CYCLES clocks and raises
//                tim_over at 00:00 until tim_en is dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_timer #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tim_en,
    input  logic [3:0] mindec_set,
    input  logic [3:0] minone_set,
    input  logic [3:0] secdec_set,
    input  logic [3:0] secone_set,
    output logic       tim_over,
    output logic       busy,
    output logic [3:0] mindec_rem,
    output logic [3:0] minone_rem,
    output logic [3:0] secdec_rem,
    output logic [3:0] secone_rem
);

    localparam int c_presc_w = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_presc_w-1:0] c_tick_last = c_presc_w'(TICK_CYCLES - 1);
    localparam logic [c_presc_w-1:0] c_presc_one = c_presc_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_en_q;
    logic [15:0]            r_count;    // {mindec, minone, secdec, secone}
    logic [c_presc_w-1:0]   r_presc;

    logic                   w_start;
    logic [15:0]            w_preset;
    logic                   w_preset_zero;
    logic                   w_tick;
    logic                   w_last_tick;
    logic [15:0]            w_count_dec;

    // Units digits saturate at 9
    function automatic logic [3:0] clamp_units(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Tens digits saturate at 5
    function automatic logic [3:0] clamp_tens(input logic [3:0] d);
        return (d > 4'd5) ? 4'd5 : d;
    endfunction

    // One-second BCD decrement with borrow across mm:ss; 00:00 never reaches
    // here because the last tick leaves RUN.
    function automatic logic [15:0] dec_mmss(input logic [15:0] c);
        logic [15:0] r;
        r = c;
        if (c[3:0] != 4'd0) begin
            r[3:0] = c[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (c[7:4] != 4'd0) begin
                r[7:4] = c[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (c[11:8] != 4'd0) begin
                    r[11:8] = c[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = c[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign w_start       = tim_en & ~r_en_q;
    assign w_preset      = {clamp_tens(mindec_set), clamp_units(minone_set),
                            clamp_tens(secdec_set), clamp_units(secone_set)};
    assign w_preset_zero = (w_preset == 16'h0000);
    assign w_tick        = (r_presc == c_tick_last);
    assign w_last_tick   = (r_count == 16'h0001);
    assign w_count_dec   = dec_mmss(r_count);

    // Handshake FSM, prescaler, count register and tim_en edge detector
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_en_q  <= 1'b0;
            r_count <= 16'h0000;
            r_presc <= '0;
        end else begin
            r_en_q <= tim_en;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_count <= w_preset;
                        r_presc <= '0;
                        r_state <= w_preset_zero ? ST_EXPIRED : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Abort wins over a coincident tick: count stays frozen
                    if (!tim_en) begin
                        r_state <= ST_IDLE;
                        r_presc <= '0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        r_count <= w_count_dec;
                        if (w_last_tick) begin
                            r_state <= ST_EXPIRED;
                        end
                    end else begin
                        r_presc <= r_presc + c_presc_one;
                    end
                end
                ST_EXPIRED: begin
                    if (!tim_en) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status flags come straight off the state register
    assign busy     = (r_state == ST_RUN);
    assign tim_over = (r_state == ST_EXPIRED);

    assign mindec_rem = r_count[15:12];
    assign minone_rem = r_count[11:8];
    assign secdec_rem = r_count[7:4];
    assign secone_rem = r_count[3:0];

endmodule
`default_nettype wire

// File: tb/tb_alarm_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_timer
//  Description : Directed vector bench for alarm_timer with TICK_CYCLES = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_timer;

    localparam int TICK = 4;

    logic       clk;
    logic       rstn;
    logic       tim_en;
    logic [3:0] mindec_set;
    logic [3:0] minone_set;
    logic [3:0] secdec_set;
    logic [3:0] secone_set;
    logic       tim_over;
    logic       busy;
    logic [3:0] mindec_rem;
    logic [3:0] minone_rem;
    logic [3:0] secdec_rem;
    logic [3:0] secone_rem;

    int checks = 0;
    int errors = 0;

    alarm_timer #(.TICK_CYCLES(TICK)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tim_en     (tim_en),
        .mindec_set (mindec_set),
        .minone_set (minone_set),
        .secdec_set (secdec_set),
        .secone_set (secone_set),
        .tim_over   (tim_over),
        .busy       (busy),
        .mindec_rem (mindec_rem),
        .minone_rem (minone_rem),
        .secdec_rem (secdec_rem),
        .secone_rem (secone_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: drive inputs, advance cyc edges, then compare
    typedef struct {
        bit          rstn;
        bit          en;
        logic [15:0] preset;
        int          cyc;
        logic        busy;
        logic        over;
        logic [15:0] rem;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit e, input logic [15:0] p, input int c,
                       input logic b, input logic o, input logic [15:0] m);
        vec_t v;
        v.rstn = r; v.en = e; v.preset = p; v.cyc = c;
        v.busy = b; v.over = o; v.rem = m;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic b, input logic o,
                         input logic [15:0] m);
        logic [17:0] act;
        logic [17:0] exp;
        act = {busy, tim_over, mindec_rem, minone_rem, secdec_rem, secone_rem};
        exp = {b, o, m};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s busy/over/rem got %b/%b/%h expected %b/%b/%h",
                     name, act[17], act[16], act[15:0], exp[17], exp[16], exp[15:0]);
        end
    endtask

    task automatic drive_preset(input logic [15:0] p);
        mindec_set = p[15:12];
        minone_set = p[11:8];
        secdec_set = p[7:4];
        secone_set = p[3:0];
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn   = 1'b0;
        tim_en = 1'b0;
        drive_preset(16'h0000);

        // Reset state
        add(0, 0, 16'h0000,  2, 0, 0, 16'h0000);
        add(1, 0, 16'h0003,  1, 0, 0, 16'h0000);
        // Basic countdown, preset 00:03
        add(1, 1, 16'h0003,  1, 1, 0, 16'h0003);
        add(1, 1, 16'h0003,  3, 1, 0, 16'h0003);
        add(1, 1, 16'h0003,  1, 1, 0, 16'h0002);
        add(1, 1, 16'h0003,  4, 1, 0, 16'h0001);
        add(1, 1, 16'h0003,  3, 1, 0, 16'h0001);
        add(1, 1, 16'h0003,  1, 0, 1, 16'h0000);
        add(1, 1, 16'h0003, 20, 0, 1, 16'h0000);
        add(1, 0, 16'h0003,  1, 0, 0, 16'h0000);
        // Borrow chain
        add(1, 1, 16'h1000,  1, 1, 0, 16'h1000);
        add(1, 1, 16'h1000,  4, 1, 0, 16'h0959);
        add(1, 0, 16'h1000,  1, 0, 0, 16'h0959);
        add(1, 1, 16'h0100,  1, 1, 0, 16'h0100);
        add(1, 1, 16'h0100,  4, 1, 0, 16'h0059);
        add(1, 0, 16'h0100,  1, 0, 0, 16'h0059);
        add(1, 1, 16'h0010,  1, 1, 0, 16'h0010);
        add(1, 1, 16'h0010,  4, 1, 0, 16'h0009);
        add(1, 0, 16'h0010,  1, 0, 0, 16'h0009);
        // Clamp
        add(1, 1, 16'hFFFF,  1, 1, 0, 16'h5959);
        add(1, 1, 16'hFFFF,  4, 1, 0, 16'h5958);
        add(1, 0, 16'hFFFF,  1, 0, 0, 16'h5958);
        add(1, 1, 16'h738C,  1, 1, 0, 16'h5359);
        add(1, 0, 16'h738C,  1, 0, 0, 16'h5359);
        // Zero preset
        add(1, 1, 16'h0000,  1, 0, 1, 16'h0000);
        add(1, 1, 16'h0000,  3, 0, 1, 16'h0000);
        add(1, 0, 16'h0000,  1, 0, 0, 16'h0000);
        // Abort at cycle 9, then reload
        add(1, 1, 16'h0005,  1, 1, 0, 16'h0005);
        add(1, 1, 16'h0005,  8, 1, 0, 16'h0003);
        add(1, 0, 16'h0005,  1, 0, 0, 16'h0003);
        add(1, 0, 16'h0005, 10, 0, 0, 16'h0003);
        add(1, 1, 16'h0005,  1, 1, 0, 16'h0005);
        // Abort coinciding with prescaler wrap: no decrement
        add(1, 1, 16'h0005,  3, 1, 0, 16'h0005);
        add(1, 0, 16'h0005,  1, 0, 0, 16'h0005);
        add(1, 0, 16'h0005,  4, 0, 0, 16'h0005);
        // Reset mid-run at 00:02, tim_en held high
        add(1, 1, 16'h0003,  1, 1, 0, 16'h0003);
        add(1, 1, 16'h0003,  4, 1, 0, 16'h0002);
        add(0, 1, 16'h0003,  1, 0, 0, 16'h0000);
        add(1, 1, 16'h0003,  1, 1, 0, 16'h0003);
        add(1, 1, 16'h0003,  4, 1, 0, 16'h0002);
        add(1, 0, 16'h0003,  1, 0, 0, 16'h0002);

        for (int i = 0; i < vecs.size(); i++) begin
            rstn   = vecs[i].rstn;
            tim_en = vecs[i].en;
            drive_preset(vecs[i].preset);
            step(vecs[i].cyc);
            check($sformatf("vec%0d", i), vecs[i].busy, vecs[i].over, vecs[i].rem);
        end

        // Exact expiry edge for 00:02: tim_over rises 8 edges after RUN entry,
        // busy falls on the same edge, and busy never drops earlier.
        begin
            int  n;
            bit  early;
            drive_preset(16'h0002);
            tim_en = 1'b1;
            step(1);
            check("expiry_entry", 1'b1, 1'b0, 16'h0002);
            n     = 0;
            early = 1'b0;
            while (!tim_over && n < 100) begin
                step(1);
                n++;
                if (!tim_over && !busy) early = 1'b1;
            end
            checks++;
            if (n != 2 * TICK || early) begin
                errors++;
                $display("FAIL expiry_edge got %0d cycles (busy dropped early %0b) expected %0d",
                         n, early, 2 * TICK);
            end
            check("expiry_state", 1'b0, 1'b1, 16'h0000);
            tim_en = 1'b0;
            step(1);
            check("expiry_release", 1'b0, 1'b0, 16'h0000);
        end

        // Zero preset: busy must never assert while tim_over holds
        begin
            bit seen_busy;
            seen_busy = 1'b0;
            drive_preset(16'h0000);
            tim_en = 1'b1;
            for (int k = 0; k < 6; k++) begin
                step(1);
                if (busy) seen_busy = 1'b1;
            end
            checks++;
            if (seen_busy) begin
                errors++;
                $display("FAIL zero_busy got busy=1 expected busy=0");
            end
            check("zero_hold", 1'b0, 1'b1, 16'h0000);
            tim_en = 1'b0;
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
